// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 constants and the fetch queue entry type
package riscv_pkg;

    localparam int XLEN = 32;

    // Major opcodes (instr[6:0]) that decode and ImmGen key on
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetchq_ram.sv
// rtl/fetchq_ram.sv - DEPTH x fetch_entry_t storage, sync write, async read
//
// Ports:
//   clk    in   write clock, rising edge
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   entry to store
//   raddr  in   read index
//   rdata  out  entry at raddr (combinational)
// The array has no reset; the owner gates rdata while it holds no valid entry.
module fetchq_ram
    import riscv_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  fetch_entry_t             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output fetch_entry_t             rdata
);

    fetch_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order {pc, instr} buffer between fetch and decode
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous discard of every entry (redirect)
//   in_valid   in   fetch presents {in_pc, in_instr}
//   in_ready   out  queue accepts the entry this cycle
//   in_pc      in   pc of the fetched instruction
//   in_instr   in   fetched instruction word
//   out_valid  out  head entry available to decode
//   out_ready  in   decode consumes the head this cycle
//   out_pc     out  pc of head entry, 0 when out_valid=0
//   out_instr  out  instr of head entry, 0 when out_valid=0
//   count      out  number of occupied entries
//
// Build option FETCHQ_BYPASS_EN: while the queue is empty and not flushing,
// the fetch side is forwarded straight to the decode side; if decode takes it
// in the same cycle the entry is never written.
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instr,
    output logic [$clog2(DEPTH):0]     count
);

    import riscv_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    fetch_entry_t head;
    fetch_entry_t wentry;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic bypass_take;
    logic wr_en;
    logic rd_en;
    logic [XLEN-1:0] sel_pc;
    logic [XLEN-1:0] sel_instr;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign in_ready = !flush && !full;

`ifdef FETCHQ_BYPASS_EN
    logic bypass_on;
    assign bypass_on   = empty && !flush;
    assign out_valid   = bypass_on ? in_valid : (!flush && !empty);
    assign sel_pc      = bypass_on ? in_pc    : head.pc;
    assign sel_instr   = bypass_on ? in_instr : head.instr;
    // Forwarded entry taken by decode this cycle: nothing to store or pop
    assign bypass_take = bypass_on && in_valid && out_ready;
`else
    assign out_valid   = !flush && !empty;
    assign sel_pc      = head.pc;
    assign sel_instr   = head.instr;
    assign bypass_take = 1'b0;
`endif

    // Zero when idle so decode sees an illegal op and ImmGen returns 0
    assign out_pc    = out_valid ? sel_pc    : '0;
    assign out_instr = out_valid ? sel_instr : '0;
    assign count     = count_q;

    assign push  = in_valid && in_ready;
    assign pop   = out_valid && out_ready;
    assign wr_en = push && !bypass_take;
    assign rd_en = pop && !bypass_take;

    assign wentry.pc    = in_pc;
    assign wentry.instr = in_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    fetchq_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wentry),
        .raddr (rd_ptr),
        .rdata (head)
    );

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_en && empty));
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= FULL_CNT);
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;
    import riscv_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: a plain queue of {pc, instr}
    logic [63:0] q[$];
    logic m_push = 1'b0;
    logic m_pop = 1'b0;
    logic m_flush = 1'b0;
    logic m_skip = 1'b0;

    always @(negedge clk) begin
        logic e_ir, e_ov;
        logic [31:0] e_pc, e_in;
        int sz;
        sz   = q.size();
        e_ir = !flush && (sz != DEPTH);
        e_ov = !flush && (sz != 0);
        e_pc = (sz != 0) ? q[0][63:32] : 32'h0;
        e_in = (sz != 0) ? q[0][31:0]  : 32'h0;
`ifdef FETCHQ_BYPASS_EN
        if (sz == 0 && !flush) begin
            e_ov = in_valid;
            e_pc = in_pc;
            e_in = in_instr;
        end
`endif
        if (!e_ov) begin
            e_pc = 32'h0;
            e_in = 32'h0;
        end
        check("cyc_in_ready",  32'(in_ready),  32'(e_ir));
        check("cyc_out_valid", 32'(out_valid), 32'(e_ov));
        check("cyc_out_pc",    out_pc,         e_pc);
        check("cyc_out_instr", out_instr,      e_in);
        check("cyc_count",     32'(count),     32'(sz));
        m_push  = in_valid && e_ir;
        m_pop   = e_ov && out_ready;
        m_flush = flush;
        m_skip  = (sz == 0) && m_push && m_pop;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (m_flush) begin
                q.delete();
            end else if (!m_skip) begin
                if (m_pop && q.size() != 0) void'(q.pop_front());
                if (m_push) q.push_back({in_pc, in_instr});
            end
        end
        m_push = 1'b0;
        m_pop = 1'b0;
        m_flush = 1'b0;
        m_skip = 1'b0;
    end

    always @(negedge rst_n) begin
        q.delete();
        m_push = 1'b0;
        m_pop = 1'b0;
        m_flush = 1'b0;
        m_skip = 1'b0;
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        in_valid = v;
        in_pc    = pc;
        in_instr = ins;
    endtask

    initial begin
        logic [31:0] imm;
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        next();
        next();
        rst_n = 1'b1;

        // 1: reset then idle
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_count",     32'(count),     32'd0);
        check("rst_out_instr", out_instr,      32'd0);
        next();

        // 2: fill to full, 9th offer refused, drain in order
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 32'h1000_0013 + 32'(i));
            next();
        end
        drive(1'b1, 32'h120, 32'h1000_0093);
        @(negedge clk);
        check("full_count",    32'(count),    32'd8);
        check("full_in_ready", 32'(in_ready), 32'd0);
        next();
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("full_count_after_9th", 32'(count), 32'd8);
        next();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("drain_pc", out_pc, 32'h100 + 32'(4 * i));
            next();
        end
        @(negedge clk);
        check("drain_count", 32'(count), 32'd0);
        next();

        // 3: streaming, pointers wrap twice
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 32'h0000_0013 + 32'(i << 7));
            @(negedge clk);
`ifdef FETCHQ_BYPASS_EN
            check("stream_count", 32'(count), 32'd0);
            check("stream_pc",    out_pc,     32'h300 + 32'(4 * i));
`else
            if (i > 0) begin
                check("stream_count", 32'(count), 32'd1);
                check("stream_pc",    out_pc,     32'h300 + 32'(4 * (i - 1)));
            end
`endif
            next();
        end
        drive(1'b0, 32'h0, 32'h0);
        next();
        out_ready = 1'b0;
        next();

        // 4: flush drops everything, including the flush-cycle offer
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i), NOP);
            next();
        end
        drive(1'b1, 32'h4FC, NOP);
        flush = 1'b1;
        next();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("flush_count",     32'(count),     32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        next();
        drive(1'b1, 32'h200, NOP);
        next();
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("post_flush_pc", out_pc, 32'h200);
        next();
        out_ready = 1'b1;
        next();
        out_ready = 1'b0;

        // 5: async reset mid-traffic
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), NOP);
            next();
        end
        drive(1'b1, 32'h50C, NOP);
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_count",     32'(count),    32'd0);
        check("arst_in_ready",  32'(in_ready), 32'd1);
        drive(1'b0, 32'h0, 32'h0);
        out_ready = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        next();
        rst_n = 1'b1;
        drive(1'b1, 32'h600, NOP);
        next();
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("post_rst_pc", out_pc, 32'h600);
        next();
        out_ready = 1'b1;
        next();
        out_ready = 1'b0;

        // 6: addi x1,x0,10 passes through untouched
        drive(1'b1, 32'h700, 32'h00A00093);
        next();
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("addi_instr",  out_instr, 32'h00A00093);
        check("addi_opcode", 32'(out_instr[6:0]), 32'(OP_IMM));
        imm = {{20{out_instr[31]}}, out_instr[31:20]};
        check("addi_imm",    imm, 32'd10);
        next();
        out_ready = 1'b1;
        next();
        out_ready = 1'b0;
        next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
